// File: rtl/icache_pkg.sv
// icache_pkg: geometry constants and FSM state encoding shared by the instruction cache files
package icache_pkg;
  localparam int ADDR_W     = 10;
  localparam int TAG_W      = 3;
  localparam int INDEX_W    = 3;
  localparam int OFFSET_W   = 2;
  localparam int BLOCK_W    = 128;
  localparam int NUM_BLOCKS = 8;
  typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_e;
endpackage

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage; async read, sync write on we_i, async clear on rst
//   clk, rst         clock, asynchronous active-high clear
//   ridx_i           read index -> valid_o, tag_o, data_o (combinational)
//   we_i, widx_i     write strobe and index
//   wtag_i, wdata_i  tag and block written; the written block becomes valid
module icache_array
  import icache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INDEX_W-1:0]   ridx_i,
  output logic                 valid_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic [BLOCK_W-1:0]   data_o,
  input  logic                 we_i,
  input  logic [INDEX_W-1:0]   widx_i,
  input  logic [TAG_W-1:0]     wtag_i,
  input  logic [BLOCK_W-1:0]   wdata_i
);
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (we_i) begin
      valid_q[widx_i] <= 1'b1;
      tag_q[widx_i]   <= wtag_i;
      data_q[widx_i]  <= wdata_i;
    end
  assign valid_o = valid_q[ridx_i];
  assign tag_o   = tag_q[ridx_i];
  assign data_o  = data_q[ridx_i];
endmodule

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped read-only instruction cache between CPU fetch and instruction memory
//   CLK, RESET             clock, asynchronous active-high reset
//   ADDRESS                CPU byte address: tag [9:7], index [6:4], word [3:2]
//   READDATA, BUSYWAIT     instruction word and stall request to the CPU
//   MEM_READ, MEM_ADDRESS  block read request and {tag,index} to memory
//   MEM_READDATA           returned 128-bit block, MEM_BUSYWAIT memory busy
//   HIT_COUNT, MISS_COUNT  saturating statistics, only when ICACHE_STATS_EN is defined
module instr_cache
  import icache_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic [ADDR_W-1:0]   ADDRESS,
  output logic [31:0]         READDATA,
  output logic                BUSYWAIT,
  output logic                MEM_READ,
  output logic [5:0]          MEM_ADDRESS,
  input  logic [BLOCK_W-1:0]  MEM_READDATA,
  input  logic                MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]         HIT_COUNT,
  output logic [15:0]         MISS_COUNT
`endif
);
  state_e               state_q, state_d;
  logic [5:0]           miss_q, miss_d;
  logic [BLOCK_W-1:0]   blk_q, blk_d;
  logic                 valid;
  logic [TAG_W-1:0]     tag;
  logic [BLOCK_W-1:0]   data;
  logic                 hit;
  logic                 unused;
  assign unused = ^ADDRESS[1:0];
  icache_array u_array (
    .clk     (CLK),
    .rst     (RESET),
    .ridx_i  (ADDRESS[6:4]),
    .valid_o (valid),
    .tag_o   (tag),
    .data_o  (data),
    .we_i    (state_q == S_UPDATE),
    .widx_i  (miss_q[2:0]),
    .wtag_i  (miss_q[5:3]),
    .wdata_i (blk_q)
  );
  assign hit      = state_q == S_IDLE && valid && tag == ADDRESS[9:7];
  assign READDATA = data[{ADDRESS[3:2], 5'b0} +: 32];
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q <= S_IDLE;
      miss_q  <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      blk_q   <= blk_d;
    end
  always_comb begin
    state_d = state_q == S_IDLE     ? (hit ? S_IDLE : S_MEM_READ) :
              state_q == S_MEM_READ ? (MEM_BUSYWAIT ? S_MEM_READ : S_UPDATE) :
                                      S_IDLE;
    miss_d  = (state_q == S_IDLE && !hit) ? ADDRESS[9:4] : miss_q;
    blk_d   = (MEM_READ && !MEM_BUSYWAIT) ? MEM_READDATA : blk_q;
  end
  always_comb begin
    BUSYWAIT    = !RESET && !hit;
    MEM_READ    = state_q == S_MEM_READ;
    MEM_ADDRESS = miss_q;
  end
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= (hit && !(&hit_cnt_q)) ? hit_cnt_q + 16'd1 : hit_cnt_q;
      miss_cnt_q <= (state_q == S_IDLE && !hit && !(&miss_cnt_q)) ? miss_cnt_q + 16'd1 : miss_cnt_q;
    end
  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif
endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: scoreboard bench for instr_cache with a 4-cycle-busy block memory model
module tb_instr_cache;
  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [9:0]   ADDRESS = '0;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [15:0]  HIT_COUNT, MISS_COUNT;
`endif
  instr_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .READDATA     (READDATA),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );
  always #5 CLK = ~CLK;
  int mcnt = 0;
  logic [31:0] k;
  always @(posedge CLK) mcnt <= (MEM_READ && MEM_BUSYWAIT) ? mcnt + 1 : 0;
  assign MEM_BUSYWAIT = MEM_READ && mcnt != 4;
  assign k = 32'(MEM_ADDRESS);
  assign MEM_READDATA = {k * 4 + 3, k * 4 + 2, k * 4 + 1, k * 4};
  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  bit active = 0;
  int busy = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge CLK) begin
    if (RESET) busy = 0;
    else if (BUSYWAIT) busy++;
    else if (active) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch: got data %0h expected none", READDATA);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("readdata", READDATA, e.data);
        check("stall_cycles", 32'(busy), 32'(e.lat));
      end
      busy = 0;
    end
  end
  task automatic fetch(input logic [9:0] a, input logic [31:0] d, input bit miss, input logic [5:0] ma);
    int mr, n;
    sb.push_back('{d, miss ? 7 : 0});
    ADDRESS = a;
    mr = 0;
    n = 0;
    forever begin
      @(negedge CLK);
      if (MEM_READ) begin
        mr++;
        check("mem_address", 32'(MEM_ADDRESS), 32'(ma));
      end
      if (!BUSYWAIT) break;
      if (++n > 60) begin
        checks++;
        errors++;
        $display("FAIL fetch_timeout: got busy %0d cycles expected at most 60", n);
        break;
      end
    end
    check("mem_read_cycles", 32'(mr), miss ? 32'd5 : 32'd0);
    @(posedge CLK);
    #1;
  endtask
  initial begin
    int mr, n;
    repeat (2) @(negedge CLK);
    check("rst_readdata", READDATA, 32'd0);
    check("rst_busywait", 32'(BUSYWAIT), 32'd0);
    check("rst_mem_read", 32'(MEM_READ), 32'd0);
    check("rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
    RESET = 1'b0;
    active = 1;
    fetch(10'h000, 32'd0, 1, 6'd0);
    fetch(10'h004, 32'd1, 0, 6'd0);
    fetch(10'h008, 32'd2, 0, 6'd0);
    fetch(10'h00C, 32'd3, 0, 6'd0);
    fetch(10'h080, 32'd32, 1, 6'd8);
    fetch(10'h084, 32'd33, 0, 6'd0);
    fetch(10'h000, 32'd0, 1, 6'd0);
    fetch(10'h00C, 32'd3, 0, 6'd0);
    active = 0;
    ADDRESS = 10'h010;
    repeat (3) @(negedge CLK);
    check("pre_rst_mem_read", 32'(MEM_READ), 32'd1);
    #1 RESET = 1'b1;
    #1;
    check("midrst_mem_read", 32'(MEM_READ), 32'd0);
    check("midrst_busywait", 32'(BUSYWAIT), 32'd0);
    check("midrst_mem_address", 32'(MEM_ADDRESS), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    active = 1;
    fetch(10'h000, 32'd0, 1, 6'd0);
    fetch(10'h004, 32'd1, 0, 6'd0);
    sb.push_back('{32'd8, 14});
    ADDRESS = 10'h010;
    mr = 0;
    n = 0;
    forever begin
      @(negedge CLK);
      if (n == 2) ADDRESS = 10'h020;
      if (MEM_READ) begin
        check("redirect_mem_address", 32'(MEM_ADDRESS), mr < 5 ? 32'd1 : 32'd2);
        mr++;
      end
      if (!BUSYWAIT) break;
      if (++n > 60) begin
        checks++;
        errors++;
        $display("FAIL redirect_timeout: got busy %0d cycles expected at most 60", n);
        break;
      end
    end
    check("redirect_mem_read_cycles", 32'(mr), 32'd10);
    @(posedge CLK);
    #1;
    fetch(10'h010, 32'd4, 0, 6'd0);
    fetch(10'h01C, 32'd7, 0, 6'd0);
    fetch(10'h028, 32'd10, 0, 6'd0);
`ifdef ICACHE_STATS_EN
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("stats_rst_hits", 32'(HIT_COUNT), 32'd0);
    RESET = 1'b0;
    fetch(10'h000, 32'd0, 1, 6'd0);
    fetch(10'h004, 32'd1, 0, 6'd0);
    fetch(10'h008, 32'd2, 0, 6'd0);
    fetch(10'h00C, 32'd3, 0, 6'd0);
    check("miss_count", 32'(MISS_COUNT), 32'd1);
    check("hit_count", 32'(HIT_COUNT), 32'd4);
`endif
    active = 0;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
